// File: rtl/snake_session_ctrl_if.sv
// Session controller bundle: button/watch/engine inputs and the phase,
// enable, reset-pulse and high-score outputs.
//   start            raw start button (async to CLK1_50)
//   stop, dead       watch-expired and collision levels
//   score_h/score_l  current BCD score
//   game_en/watch_en run enables, game_rst one-cycle reset pulse
//   hi_h/hi_l        BCD high score, state current phase
// master drives the inputs of the controller, slave is the controller side.
interface snake_session_ctrl_if;
    logic       start;
    logic       stop;
    logic       dead;
    logic [3:0] score_h;
    logic [3:0] score_l;
    logic       game_en;
    logic       watch_en;
    logic       game_rst;
    logic [3:0] hi_h;
    logic [3:0] hi_l;
    logic [1:0] state;

    modport master (
        output start, stop, dead, score_h, score_l,
        input  game_en, watch_en, game_rst, hi_h, hi_l, state
    );

    modport slave (
        input  start, stop, dead, score_h, score_l,
        output game_en, watch_en, game_rst, hi_h, hi_l, state
    );
endinterface

// File: rtl/snake_session_ctrl.sv
// Session sequencer for the snake game box: synchronizes and debounces the
// start button, steps IDLE -> ARM -> PLAY -> OVER -> IDLE, drives the game and
// watch run enables plus a one-cycle reset pulse, and keeps a BCD high score.
// Ports:
//   CLK1_50  system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      snake_session_ctrl_if.slave (start/stop/dead/score in,
//            game_en/watch_en/game_rst/hi_h/hi_l/state out, all registered)
// Build option: define HISCORE_EN to build the high-score register and
// comparator; otherwise hi_h/hi_l are tied to 0.
module snake_session_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
    parameter int unsigned OVER_HOLD_CYCLES = 150_000_000,
    parameter int unsigned CNT_W            = 28
) (
    input  logic               CLK1_50,
    input  logic               RESET_N,
    snake_session_ctrl_if.slave bus
);

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
    localparam logic [ST_W-1:0] ST_ARM  = 2'b01;
    localparam logic [ST_W-1:0] ST_PLAY = 2'b10;
    localparam logic [ST_W-1:0] ST_OVER = 2'b11;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(OVER_HOLD_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic [CNT_W-1:0] deb_cnt_q;
    logic             start_evt_q;

    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             game_en_q;
    logic             watch_en_q;
    logic             game_rst_q;
    logic             game_en_d;
    logic             watch_en_d;
    logic             game_rst_d;
    logic             game_end_c;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.start;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: a level change is accepted after DEBOUNCE_CYCLES consecutive
    // differing samples; start_evt marks the accepted rising level.
    always_ff @(posedge CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            start_evt_q <= 1'b0;
        end else begin
            start_evt_q <= 1'b0;
            if (sync2_q != deb_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    deb_q       <= sync2_q;
                    deb_cnt_q   <= '0;
                    start_evt_q <= sync2_q;
                end else begin
                    deb_cnt_q <= deb_cnt_q + CNT_W'(1);
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    // Phase sequencing; outputs are decoded from the next phase and registered.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        game_end_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_evt_q) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.stop || bus.dead) begin
                    state_d    = ST_OVER;
                    hold_d     = '0;
                    game_end_c = 1'b1;
                end
            end
            ST_OVER: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        game_en_d  = (state_d == ST_PLAY);
        watch_en_d = (state_d == ST_PLAY);
        game_rst_d = (state_d == ST_ARM);
    end

    always_ff @(posedge CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            game_en_q  <= 1'b0;
            watch_en_q <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            game_en_q  <= game_en_d;
            watch_en_q <= watch_en_d;
            game_rst_q <= game_rst_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.game_en  = game_en_q;
    assign bus.watch_en = watch_en_q;
    assign bus.game_rst = game_rst_q;

`ifdef HISCORE_EN
    logic [7:0] hi_q;

    // BCD ordering matches binary ordering, so a plain unsigned compare works.
    always_ff @(posedge CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hi_q <= '0;
        end else if (game_end_c && ({bus.score_h, bus.score_l} > hi_q)) begin
            hi_q <= {bus.score_h, bus.score_l};
        end
    end

    assign bus.hi_h = hi_q[7:4];
    assign bus.hi_l = hi_q[3:0];
`else
    // Score and game-end strobe are only consumed by the high-score logic.
    logic unused_score;
    assign unused_score = ^{bus.score_h, bus.score_l, game_end_c};

    assign bus.hi_h = 4'h0;
    assign bus.hi_l = 4'h0;
`endif

endmodule

// File: tb/tb_snake_session_ctrl.sv
module tb_snake_session_ctrl;

    localparam int D = 4;
    localparam int H = 8;

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_ARM  = 2'd1;
    localparam logic [1:0] P_PLAY = 2'd2;
    localparam logic [1:0] P_OVER = 2'd3;

`ifdef HISCORE_EN
    localparam logic [7:0] HI_G1 = 8'h37;
    localparam logic [7:0] HI_G2 = 8'h37;
    localparam logic [7:0] HI_G3 = 8'h41;
`else
    localparam logic [7:0] HI_G1 = 8'h00;
    localparam logic [7:0] HI_G2 = 8'h00;
    localparam logic [7:0] HI_G3 = 8'h00;
`endif

    logic CLK1_50 = 1'b0;
    logic RESET_N = 1'b1;

    snake_session_ctrl_if bus();

    snake_session_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .OVER_HOLD_CYCLES(H),
        .CNT_W           (8)
    ) dut (
        .CLK1_50(CLK1_50),
        .RESET_N(RESET_N),
        .bus    (bus.slave)
    );

    always #10 CLK1_50 = ~CLK1_50;

    int checks = 0;
    int errors = 0;

    // Reference model: raw button history, debounce run length, phase timer.
    bit         raw_q[$];
    int         run_len;
    bit         deb_lvl;
    bit         evt;
    logic [1:0] phase;
    int         over_left;
    logic [7:0] hi_m;

    typedef struct {
        bit          start;
        bit          stop;
        bit          dead;
        logic [7:0]  score;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [12:0] mk(logic [1:0] st, bit ge, bit we, bit gr, logic [7:0] hi);
        return {st, ge, we, gr, hi};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.state, bus.game_en, bus.watch_en, bus.game_rst, bus.hi_h, bus.hi_l};
    endfunction

    function automatic logic [12:0] model_vec();
        return mk(phase, phase == P_PLAY, phase == P_PLAY, phase == P_ARM, hi_m);
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q     = '{1'b0, 1'b0};
        run_len   = 0;
        deb_lvl   = 1'b0;
        evt       = 1'b0;
        phase     = P_IDLE;
        over_left = 0;
        hi_m      = 8'h00;
    endtask

    task automatic model_step();
        bit syn;
        syn = raw_q.pop_front();
        raw_q.push_back(bus.start);
        case (phase)
            P_IDLE: if (evt) phase = P_ARM;
            P_ARM:  phase = P_PLAY;
            P_PLAY: begin
                if (bus.stop || bus.dead) begin
`ifdef HISCORE_EN
                    if ({bus.score_h, bus.score_l} > hi_m) hi_m = {bus.score_h, bus.score_l};
`endif
                    phase     = P_OVER;
                    over_left = H;
                end
            end
            default: begin
                over_left--;
                if (over_left == 0) phase = P_IDLE;
            end
        endcase
        evt = 1'b0;
        if (syn != deb_lvl) begin
            run_len++;
            if (run_len == D) begin
                deb_lvl = syn;
                run_len = 0;
                evt     = syn;
            end
        end else begin
            run_len = 0;
        end
    endtask

    task automatic cycle();
        @(posedge CLK1_50);
        model_step();
        #1;
        check("model", 16'(dut_vec()), 16'(model_vec()));
    endtask

    task automatic set_in(bit s, bit p, bit d, logic [7:0] sc);
        bus.start   = s;
        bus.stop    = p;
        bus.dead    = d;
        bus.score_h = sc[7:4];
        bus.score_l = sc[3:0];
    endtask

    task automatic apply_reset();
        RESET_N = 1'b0;
        #1;
        model_reset();
        check("reset_async", 16'(dut_vec()), 16'h0000);
        repeat (2) @(posedge CLK1_50);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic wait_phase(logic [1:0] target, int max_cycles, string name);
        int n = 0;
        while (phase != target && n < max_cycles) begin
            cycle();
            n++;
        end
        if (phase != target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for phase %0d, got %0d", name, target, phase);
        end
    endtask

    task automatic to_play();
        bus.start = 1'b1;
        wait_phase(P_PLAY, 20, "to_play");
        bus.start = 1'b0;
    endtask

    task automatic play_game(logic [7:0] sc, bit use_stop, logic [7:0] exp_hi);
        to_play();
        repeat (3) cycle();
        set_in(1'b0, use_stop, !use_stop, sc);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, sc);
        check("end_state", 16'(bus.state), 16'(P_OVER));
        check("end_hi", 16'({bus.hi_h, bus.hi_l}), 16'(exp_hi));
        wait_phase(P_IDLE, 20, "game_idle");
        repeat (8) cycle();
    endtask

    task automatic add(bit s, bit p, bit d, logic [7:0] sc, logic [12:0] e);
        vec_t v;
        v.start = s; v.stop = p; v.dead = d; v.score = sc; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        apply_reset();

        // Quiet reset: nothing changes for 100 cycles.
        for (int i = 0; i < 100; i++) cycle();
        check("idle_100", 16'(dut_vec()), 16'h0000);

        // Clean press, full game ending on stop+dead with score 0x37, held button.
        for (int i = 0; i < 6; i++) add(1, 0, 0, 8'h37, mk(P_IDLE, 0, 0, 0, 8'h00));
        add(1, 0, 0, 8'h37, mk(P_ARM, 0, 0, 1, 8'h00));
        for (int i = 0; i < 3; i++) add(1, 0, 0, 8'h37, mk(P_PLAY, 1, 1, 0, 8'h00));
        add(1, 1, 1, 8'h37, mk(P_OVER, 0, 0, 0, HI_G1));
        for (int i = 0; i < 7; i++) add(1, 0, 0, 8'h37, mk(P_OVER, 0, 0, 0, HI_G1));
        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h37, mk(P_IDLE, 0, 0, 0, HI_G1));
        foreach (tbl[i]) begin
            set_in(tbl[i].start, tbl[i].stop, tbl[i].dead, tbl[i].score);
            cycle();
            check($sformatf("vec[%0d]", i), 16'(dut_vec()), 16'(tbl[i].exp));
        end
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (10) cycle();

        // Bounce: 3 high, 2 low, 3 high, then low.
        for (int i = 0; i < 18; i++) begin
            bus.start = (i < 3) || (i >= 5 && i < 8);
            cycle();
            check("bounce", 16'(bus.state), 16'(P_IDLE));
        end

        play_game(8'h25, 1'b0, HI_G2);
        play_game(8'h41, 1'b1, HI_G3);

        // Start during PLAY is ignored.
        to_play();
        bus.start = 1'b1;
        repeat (8) cycle();
        bus.start = 1'b0;
        repeat (8) cycle();
        check("play_ignore", 16'(bus.state), 16'(P_PLAY));

        // Start during OVER is ignored; OVER still ends on time.
        set_in(1'b1, 1'b1, 1'b0, 8'h10);
        cycle();
        check("over_enter", 16'(bus.state), 16'(P_OVER));
        set_in(1'b1, 1'b0, 1'b0, 8'h10);
        repeat (7) cycle();
        check("over_ignore", 16'(bus.state), 16'(P_OVER));
        cycle();
        check("over_exit", 16'(bus.state), 16'(P_IDLE));
        bus.start = 1'b0;
        repeat (10) cycle();
        check("over_no_evt", 16'(bus.state), 16'(P_IDLE));

        // stop/dead in IDLE do nothing.
        set_in(1'b0, 1'b1, 1'b1, 8'h99);
        repeat (3) cycle();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) cycle();
        check("idle_stop", 16'(dut_vec()), 16'(mk(P_IDLE, 0, 0, 0, HI_G3)));

        // Reset in the middle of a game.
        to_play();
        repeat (2) cycle();
        apply_reset();
        repeat (3) cycle();
        check("mid_reset", 16'(dut_vec()), 16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.start = !bus.start;
            bus.stop    = ($urandom_range(0, 19) == 0);
            bus.dead    = ($urandom_range(0, 19) == 0);
            bus.score_h = 4'($urandom_range(0, 9));
            bus.score_l = 4'($urandom_range(0, 9));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_session_ctrl.md
# snake_session_ctrl

Session sequencer for the snake game box. It debounces the start button and steps through idle, arm, play and game-over phases. It drives the run-enables and the one-cycle reset pulse for the snake game engine and the countdown watch, and keeps a BCD high score. It sits at the top level, between the raw button and the game and watch blocks.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000 — consecutive stable samples needed to accept a button level change (20 ms at 50 MHz); must be ≥1.
- OVER_HOLD_CYCLES, 150_000_000 — length of the OVER phase in cycles (3 s); must be ≥1.
- CNT_W, 28 — width of the debounce and hold counters; must hold both parameters.

Ports:
- CLK1_50  in  1  system clock, 50 MHz. One clock; all logic on its rising edge.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- start  in  1  raw start button, active-high, asynchronous to CLK1_50.
- stop  in  1  watch-expired level from the countdown watch.
- dead  in  1  collision level from the game engine.
- score_h  in  4  current score, BCD tens digit.
- score_l  in  4  current score, BCD ones digit.
- game_en  out  1  game engine run enable (1 = running).
- watch_en  out  1  watch run enable (1 = counting).
- game_rst  out  1  one-cycle reset pulse to the game engine and the watch.
- hi_h  out  4  high score, BCD tens digit.
- hi_l  out  4  high score, BCD ones digit.
- state  out  2  phase: 00 IDLE, 01 ARM, 10 PLAY, 11 OVER.

## Operation
- Input path: two-flop synchronizer on start, then the debouncer.
- Debouncer holds an internal debounced level, reset value 0.
  - The counter increments each cycle that the synchronized level differs from the debounced level.
  - The counter clears to 0 on any cycle where the two are equal.
  - When the count reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces start_evt for exactly one cycle.
- FSM:
  - IDLE: game_en=0, watch_en=0. start_evt → ARM.
  - ARM: game_rst=1, both enables 0. Lasts exactly 1 cycle, then → PLAY.
  - PLAY: game_en=1, watch_en=1. stop or dead, including both in the same cycle → OVER. start_evt is ignored; there is no mid-game restart.
  - OVER: both enables 0. The hold counter clears on entry and increments each cycle. At OVER_HOLD_CYCLES-1 → IDLE. start_evt is ignored.
- High score:
  - Updated on the PLAY→OVER transition edge.
  - If {score_h,score_l} > {hi_h,hi_l}, compared as unsigned 8-bit values, the high score loads the current score. Valid BCD ordering equals numeric ordering, so no conversion is needed.
  - The high score is never cleared by start; only RESET_N clears it.
- All outputs are registered.

## Timing
- Reset values: state=IDLE (00); game_en, watch_en, game_rst = 0; hi_h, hi_l = 0; all counters and synchronizer flops = 0; debounced level = 0.
- RESET_N low at any time, including mid-PLAY or mid-OVER, forces the reset values immediately.
- Press latency: raw start rises before edge 0 and stays high. start_evt is high in the cycle after edge 1+DEBOUNCE_CYCLES. state=ARM and game_rst=1 one cycle later. PLAY follows one cycle after that.
- Press shorter than DEBOUNCE_CYCLES synchronized samples → no event.
- A button held through an entire game gives no new event. It must be released (debounced low) and pressed again.
- stop/dead sampled high in PLAY → state=OVER and enables 0 on the next cycle. The high score is valid in that same cycle.
- OVER lasts exactly OVER_HOLD_CYCLES cycles, then IDLE.
- stop/dead high outside PLAY → no effect.

## Configuration
- HISCORE_EN defined: the high-score register and comparator are built as described.
- HISCORE_EN undefined: hi_h and hi_l are constant 0, with no compare logic. All other behaviour is identical.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and OVER_HOLD_CYCLES=8.
- Reset: RESET_N low → state=00, all outputs 0. RESET_N high with no input → outputs unchanged for 100 cycles.
- Bounce: start high 3 cycles, low 2, high 3, low → no start_evt, state stays 00.
- Clean start: start held high → ARM with game_rst=1 for exactly 1 cycle, then PLAY with game_en=watch_en=1.
- End of game: in PLAY, score 0x37, stop and dead both pulsed 1 cycle → OVER next cycle, hi=3/7, enables 0. Exactly 8 cycles later, IDLE.
- High score keeps the maximum: second game ends with score 0x25 via dead → hi stays 3/7. Third game ends with 0x41 → hi=4/1.
- Ignored events: start pulse during PLAY and during OVER, and stop in IDLE → no state change. RESET_N low mid-PLAY → state=00, game_en=0, hi=0/0. With HISCORE_EN undefined, hi is 0/0 throughout.
